raw10_unpack: RTL and testbench

Converts the byte stream from the MIPI CSI-2 `camera` receiver into 10-bit pixels. Each RAW10 group is 5 bytes, and the block unpacks it into 4 pixels. It sits directly downstream of `camera` (4 bytes per beat on `image_data[3:0]`) and upstream of the frame-buffer arbiter, in the MIPI byte-clock domain. Unpacking is restarted on frame/line boundaries, and groups that are misaligned at a line boundary are flagged.

---
 rtl/raw10_unpack.sv | 103 ++++++++++
 tb/tb_raw10_unpack.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/raw10_unpack.sv
// RAW10 byte-stream unpacker: turns 4-byte CSI-2 beats into groups of four 10-bit pixels.
// Optional build macro RAW10_UNPACK_RAW8_EN adds a RAW8 (type 6'h2A) passthrough path.
module raw10_unpack #(
  parameter logic [5:0] RAW10_DT = 6'h2B
) (
  input  logic            mipi_clk,
  input  logic            resetn,
  input  logic [3:0][7:0] image_data,
  input  logic            image_data_enable,
  input  logic [5:0]      image_data_type,
  input  logic            frame_start,
  input  logic            line_start,
  output logic [3:0][9:0] raw,
  output logic            raw_enable,
  output logic            align_err,
  output logic [15:0]     group_count
);

  // Handshake: image_data is consumed in any cycle image_data_enable is high (no ready);
  // raw is valid for exactly the cycles raw_enable is high and the sink must take every one.

  logic            boundary;
  logic            accept_raw10;
  logic            accept_raw8;
  logic            emit;
  logic [2:0]      k_q;
  logic [2:0]      k_base;
  logic [2:0]      k_nxt;
  logic [3:0]      total;
  logic [63:0]     buf_q;
  logic [63:0]     buf_base;
  logic [63:0]     work;
  logic [63:0]     buf_nxt;
  logic [15:0]     gc_base;
  logic [15:0]     gc_inc;
  logic [3:0][9:0] group_pix;
`ifdef RAW10_UNPACK_RAW8_EN
  logic [3:0][9:0] raw8_pix;
`endif

  // Bytes above k in buf_q are always zero, so appending a beat is a shift-and-OR.
  always_comb begin
    boundary     = line_start | frame_start;
    accept_raw10 = image_data_enable && (image_data_type == RAW10_DT);
`ifdef RAW10_UNPACK_RAW8_EN
    accept_raw8  = image_data_enable && (image_data_type == 6'h2A) && !accept_raw10;
`else
    accept_raw8  = 1'b0;
`endif
    k_base   = boundary ? 3'd0 : k_q;
    buf_base = boundary ? 64'd0 : buf_q;
    work     = buf_base | ({32'd0, image_data} << {k_base, 3'b000});
    total    = {1'b0, k_base} + 4'd4;
    emit     = accept_raw10 && (total >= 4'd5);
    k_nxt    = emit ? 3'(total - 4'd5) : total[2:0];
    buf_nxt  = emit ? (work >> 40) : work;
    gc_base  = boundary ? 16'd0 : group_count;
    gc_inc   = (gc_base == 16'hFFFF) ? gc_base : gc_base + 16'd1;
    for (int i = 0; i < 4; i++) begin
      group_pix[i] = {work[8*i +: 8], work[32 + 2*i +: 2]};
    end
`ifdef RAW10_UNPACK_RAW8_EN
    for (int i = 0; i < 4; i++) begin
      raw8_pix[i] = {image_data[i], 2'b00};
    end
`endif
  end

  always_ff @(posedge mipi_clk) begin
    if (!resetn) begin
      k_q         <= 3'd0;
      buf_q       <= 64'd0;
      raw         <= '0;
      raw_enable  <= 1'b0;
      align_err   <= 1'b0;
      group_count <= 16'd0;
    end else begin
      raw_enable  <= 1'b0;
      align_err   <= boundary && (k_q != 3'd0);
      group_count <= gc_base;
      if (accept_raw10) begin
        k_q   <= k_nxt;
        buf_q <= buf_nxt;
      end else if (boundary) begin
        k_q   <= 3'd0;
        buf_q <= 64'd0;
      end
      if (emit) begin
        raw         <= group_pix;
        raw_enable  <= 1'b1;
        group_count <= gc_inc;
      end
`ifdef RAW10_UNPACK_RAW8_EN
      else if (accept_raw8) begin
        raw         <= raw8_pix;
        raw_enable  <= 1'b1;
        group_count <= gc_inc;
      end
`endif
    end
  end

endmodule

// File: tb/tb_raw10_unpack.sv
// Bench for raw10_unpack: directed line scenarios plus random traffic against a byte-queue model.
module tb_raw10_unpack;

  logic            mipi_clk = 1'b0;
  logic            resetn;
  logic [3:0][7:0] image_data;
  logic            image_data_enable;
  logic [5:0]      image_data_type;
  logic            frame_start;
  logic            line_start;
  logic [3:0][9:0] raw;
  logic            raw_enable;
  logic            align_err;
  logic [15:0]     group_count;

  raw10_unpack dut (
    .mipi_clk          (mipi_clk),
    .resetn            (resetn),
    .image_data        (image_data),
    .image_data_enable (image_data_enable),
    .image_data_type   (image_data_type),
    .frame_start       (frame_start),
    .line_start        (line_start),
    .raw               (raw),
    .raw_enable        (raw_enable),
    .align_err         (align_err),
    .group_count       (group_count)
  );

  always #5 mipi_clk = ~mipi_clk;

  int          total_n = 0;
  int          bad_n   = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  mq[$];
  int          m_gc   = 0;
  logic [39:0] m_last = '0;
  logic        exp_en;
  logic        exp_al;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_emit(input logic [39:0] grp);
    exp_q.push_back(grp);
    m_last = grp;
    exp_en = 1'b1;
    if (m_gc < 65535) m_gc++;
  endtask

  // Reference: a plain byte FIFO; every 5 bytes form a group of four pixels.
  task automatic model(input logic rst, input logic en, input logic [5:0] ty,
                       input logic [31:0] d, input logic ls, input logic fs);
    logic [7:0]  g[5];
    logic [39:0] grp;
    int          pix;
    exp_en = 1'b0;
    exp_al = 1'b0;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_gc   = 0;
      m_last = '0;
      return;
    end
    if (ls || fs) begin
      exp_al = (mq.size() != 0);
      mq.delete();
      m_gc = 0;
    end
    if (en && ty == 6'h2B) begin
      for (int b = 0; b < 4; b++) mq.push_back(d[8*b +: 8]);
      if (mq.size() >= 5) begin
        for (int i = 0; i < 5; i++) g[i] = mq.pop_front();
        grp = '0;
        for (int i = 0; i < 4; i++) begin
          pix = g[i] * 4 + ((g[4] >> (2*i)) & 3);
          grp = grp | (40'(pix) << (10*i));
        end
        model_emit(grp);
      end
    end
`ifdef RAW10_UNPACK_RAW8_EN
    else if (en && ty == 6'h2A) begin
      grp = '0;
      for (int i = 0; i < 4; i++) begin
        pix = d[8*i +: 8] * 4;
        grp = grp | (40'(pix) << (10*i));
      end
      model_emit(grp);
    end
`endif
  endtask

  task automatic step(input logic rst, input logic en, input logic [5:0] ty,
                      input logic [31:0] d, input logic ls, input logic fs);
    resetn            = !rst;
    image_data_enable = en;
    image_data_type   = ty;
    image_data        = d;
    line_start        = ls;
    frame_start       = fs;
    model(rst, en, ty, d, ls, fs);
    @(posedge mipi_clk);
    #1;
    check("raw_enable", 40'(raw_enable), 40'(exp_en));
    check("align_err", 40'(align_err), 40'(exp_al));
    check("group_count", 40'(group_count), 40'(m_gc));
    check("raw_hold", raw, m_last);
    if (raw_enable) begin
      if (exp_q.size() == 0) check("grp_extra", 40'd1, 40'd0);
      else check("grp", raw, exp_q.pop_front());
    end
  endtask

  task automatic beat(input logic [31:0] d);
    step(1'b0, 1'b1, 6'h2B, d, 1'b0, 1'b0);
  endtask

  task automatic mark_line();
    step(1'b0, 1'b0, 6'h2B, $urandom(), 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    logic [5:0]  ty;
    int          sel;

    // reset held with enable high
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 6'h2B, $urandom(), 1'b0, 1'b0);
    check("reset_raw", raw, 40'd0);

    // aligned line of bytes 0x00..0x13
    mark_line();
    for (int b = 0; b < 5; b++) begin
      d = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      beat(d);
      if (b == 1) check("aligned_grp0", raw, {10'h00C, 10'h008, 10'h005, 10'h000});
    end
    check("aligned_gc", 40'(group_count), 40'd4);

    // misaligned line: 3 beats leave k=2
    mark_line();
    for (int b = 0; b < 3; b++) beat($urandom());
    check("mis_gc", 40'(group_count), 40'd2);
    mark_line();
    check("mis_align", 40'(align_err), 40'd1);
    beat($urandom());
    check("mis_restart", 40'(raw_enable), 40'd0);

    // line_start together with a beat while k=3
    mark_line();
    beat($urandom());
    beat($urandom());
    step(1'b0, 1'b1, 6'h2B, $urandom(), 1'b1, 1'b0);
    check("sim_align", 40'(align_err), 40'd1);
    check("sim_noemit", 40'(raw_enable), 40'd0);
    beat($urandom());
    check("sim_next", 40'(raw_enable), 40'd1);

    // foreign data type interleaved between RAW10 beats
    mark_line();
    for (int b = 0; b < 12; b++) begin
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 6'h12, $urandom(), 1'b0, 1'b0);
      beat($urandom());
    end

    // RAW8 beat {FF,01,80,00}
    mark_line();
    step(1'b0, 1'b1, 6'h2A, 32'h008001FF, 1'b0, 1'b0);
`ifdef RAW10_UNPACK_RAW8_EN
    check("raw8_pass", raw, {10'h000, 10'h200, 10'h004, 10'h3FC});
`else
    check("raw8_ignored", 40'(raw_enable), 40'd0);
`endif

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 4);
      ty  = (sel == 3) ? 6'h12 : (sel == 4) ? 6'h2A : 6'h2B;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ty, $urandom(),
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    check("drain", 40'(exp_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
